// File: rtl/nibble_serializer_16_to_4_if.sv
// Handshake bundle for the nibble serializer.
//   in_valid/in_ready/in_data      : word input, producer -> serializer
//   out_valid/out_ready            : nibble output handshake, serializer -> consumer
//   out_nibble/out_index/out_last  : current beat payload
//   busy                           : a word is in flight
// modport slave is the serializer's view; modport master is the environment's view.
interface nibble_serializer_16_to_4_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NIB_CNT = 4,
    localparam int unsigned IDX_W  = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_nibble;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic              busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_nibble,
        output out_index,
        output out_last,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_nibble,
        input  out_index,
        input  out_last,
        input  busy
    );
endinterface

// File: rtl/nibble_serializer_16_to_4.sv
// Serializes a DATA_W-bit word into 4-bit nibbles, LSB nibble first.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave modport of nibble_serializer_16_to_4_if
//          - word input over in_valid/in_ready/in_data
//          - nibble output over out_valid/out_ready with out_nibble, out_index, out_last
//          - busy high while a word is in flight
// DATA_W must equal 4*NIB_CNT. With TRIM_ZEROS set, the stream ends as soon as
// every remaining upper nibble is zero (a zero word still emits one beat).
module nibble_serializer_16_to_4 #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NIB_CNT    = 4,
    parameter bit          TRIM_ZEROS = 1'b0
) (
    input logic clk,
    input logic rst,
    nibble_serializer_16_to_4_if.slave bus
);
    localparam int unsigned IDX_W = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              out_valid;
    logic              last_beat;
    logic              in_xfer;
    logic              out_xfer;
    logic [DATA_W-1:0] upper;

    // Nibbles still to come after the current one.
    assign upper     = shreg_q >> 4;
    assign last_beat = (idx_q == IDX_W'(NIB_CNT - 1)) || (TRIM_ZEROS && (upper == '0));

    assign out_valid = (state_q == StShift);
    assign out_xfer  = out_valid & bus.out_ready;
    // Combinational from out_ready so the next word can load on the last beat.
    assign bus.in_ready = !out_valid || (last_beat && bus.out_ready);
    assign in_xfer      = bus.in_valid & bus.in_ready;

    assign bus.out_valid  = out_valid;
    assign bus.out_nibble = shreg_q[3:0];
    assign bus.out_index  = idx_q;
    assign bus.out_last   = out_valid & last_beat;
    assign bus.busy       = out_valid;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (out_xfer) begin
            if (last_beat) begin
                state_d = StIdle;
            end else begin
                shreg_d = shreg_q >> 4;
                idx_d   = idx_q + IDX_W'(1);
            end
        end
        // A load wins over the last-beat return to idle.
        if (in_xfer) begin
            state_d = StShift;
            shreg_d = bus.in_data;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_nibble_serializer_16_to_4.sv
module tb_nibble_serializer_16_to_4;
    logic clk;
    logic rst;

    nibble_serializer_16_to_4_if #(.DATA_W(16), .NIB_CNT(4)) b0 ();
    nibble_serializer_16_to_4_if #(.DATA_W(16), .NIB_CNT(4)) b1 ();

    nibble_serializer_16_to_4 #(.DATA_W(16), .NIB_CNT(4), .TRIM_ZEROS(1'b0)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(b0)
    );
    nibble_serializer_16_to_4 #(.DATA_W(16), .NIB_CNT(4), .TRIM_ZEROS(1'b1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic       in_ready;
        logic       out_valid;
        logic       out_last;
        logic       busy;
        logic [3:0] nib;
        logic [1:0] idx;
    } obs_t;

    typedef struct packed {
        logic [3:0] nib;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    typedef struct {
        string       name;
        logic [15:0] data;
        bit          trim;
        logic [15:0] exp_nibs;
        int          exp_beats;
    } vec_t;

    beat_t model_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [15:0] data, input logic r);
        if (d == 0) begin
            b0.in_valid = v; b0.in_data = data; b0.out_ready = r;
        end else begin
            b1.in_valid = v; b1.in_data = data; b1.out_ready = r;
        end
    endtask

    task automatic get_obs(input int d, output obs_t o);
        if (d == 0) begin
            o.in_ready = b0.in_ready; o.out_valid = b0.out_valid; o.out_last = b0.out_last;
            o.busy = b0.busy; o.nib = b0.out_nibble; o.idx = b0.out_index;
        end else begin
            o.in_ready = b1.in_ready; o.out_valid = b1.out_valid; o.out_last = b1.out_last;
            o.busy = b1.busy; o.nib = b1.out_nibble; o.idx = b1.out_index;
        end
    endtask

    // Reference: a word becomes its list of significant nibbles, LSB first.
    function automatic void push_word(input logic [15:0] w, input bit trim);
        int    n;
        beat_t b;
        n = 4;
        if (trim) begin
            n = 1;
            for (int k = 1; k < 4; k++) if ((w >> (4 * k)) != 0) n = k + 1;
        end
        for (int i = 0; i < n; i++) begin
            b.nib  = 4'((w >> (4 * i)) & 16'hF);
            b.idx  = 2'(i);
            b.last = (i == n - 1);
            model_q.push_back(b);
        end
    endfunction

    // Load one word with out_ready high and check every beat against expectations.
    task automatic run_word(input string name, input int d, input logic [15:0] data,
                            input logic [15:0] exp_nibs, input int exp_beats);
        obs_t o;
        int   beat;
        int   cyc;
        bit   done;
        logic [15:0] nibs;
        nibs = exp_nibs;
        @(negedge clk);
        drive(d, 1'b1, data, 1'b1);
        #1 get_obs(d, o);
        check({name, " in_ready before load"}, 16'(o.in_ready), 16'd1);
        @(posedge clk);
        beat = 0; cyc = 0; done = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            drive(d, 1'b0, 16'h0, 1'b1);
            #1 get_obs(d, o);
            cyc++;
            if (cyc == 1) check({name, " first beat latency"}, 16'(o.out_valid), 16'd1);
            if (o.out_valid) begin
                check({name, " nibble"}, 16'(o.nib), 16'(nibs[4*beat +: 4]));
                check({name, " index"}, 16'(o.idx), 16'(beat));
                check({name, " last"}, 16'(o.out_last), 16'(beat == exp_beats - 1));
                if (o.out_last) done = 1;
                beat++;
            end
        end
        check({name, " beat count"}, 16'(beat), 16'(exp_beats));
        @(negedge clk);
        #1 get_obs(d, o);
        check({name, " idle out_valid"}, 16'(o.out_valid), 16'd0);
        check({name, " idle in_ready"}, 16'(o.in_ready), 16'd1);
        check({name, " idle busy"}, 16'(o.busy), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        obs_t        o;
        logic [3:0]  exp4[8];
        int          cyc;
        int          beat;
        int          last_cyc;
        logic [15:0] nibs1234;

        vecs[0] = '{"basic A5C3", 16'hA5C3, 1'b0, 16'hA5C3, 4};
        vecs[1] = '{"zero notrim", 16'h0000, 1'b0, 16'h0000, 4};
        vecs[2] = '{"trim 0034", 16'h0034, 1'b1, 16'h0034, 2};
        vecs[3] = '{"trim 0000", 16'h0000, 1'b1, 16'h0000, 1};
        vecs[4] = '{"trim 8000", 16'h8000, 1'b1, 16'h8000, 4};
        vecs[5] = '{"trim 0F00", 16'h0F00, 1'b1, 16'h0F00, 3};
        exp4 = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hD, 4'h0, 4'h0, 4'hF};
        nibs1234 = 16'h1234;

        // Reset state.
        rst = 1'b1;
        drive(0, 1'b0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0);
        #1;
        get_obs(0, o);
        check("reset in_ready", 16'(o.in_ready), 16'd1);
        check("reset out_valid", 16'(o.out_valid), 16'd0);
        check("reset busy", 16'(o.busy), 16'd0);
        check("reset last", 16'(o.out_last), 16'd0);
        check("reset nibble", 16'(o.nib), 16'd0);
        check("reset index", 16'(o.idx), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven words.
        foreach (vecs[i]) run_word(vecs[i].name, vecs[i].trim ? 1 : 0, vecs[i].data,
                                   vecs[i].exp_nibs, vecs[i].exp_beats);

        // Reset while busy: asynchronous drop between edges.
        @(negedge clk);
        drive(0, 1'b1, 16'hBEEF, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 1'b1);
        #1 get_obs(0, o);
        check("rstmid first nibble", 16'(o.nib), 16'hF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 get_obs(0, o);
        check("rstmid out_valid", 16'(o.out_valid), 16'd0);
        check("rstmid busy", 16'(o.busy), 16'd0);
        check("rstmid in_ready", 16'(o.in_ready), 16'd1);
        check("rstmid index", 16'(o.idx), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 get_obs(0, o);
        check("rstmid no replay", 16'(o.out_valid), 16'd0);
        run_word("after reset 0001", 0, 16'h0001, 16'h0001, 4);

        // Backpressure on the index-1 beat of 0x1234.
        @(negedge clk);
        drive(0, 1'b1, 16'h1234, 1'b1);
        @(posedge clk);
        cyc = 0; beat = 0; last_cyc = -1;
        while (last_cyc < 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            drive(0, 1'b0, 16'h0, !(cyc >= 2 && cyc <= 4));
            #1 get_obs(0, o);
            if (cyc >= 2 && cyc <= 4) begin
                check("bp stall nibble", 16'(o.nib), 16'h3);
                check("bp stall index", 16'(o.idx), 16'd1);
                check("bp stall in_ready", 16'(o.in_ready), 16'd0);
                check("bp stall valid", 16'(o.out_valid), 16'd1);
            end else if (o.out_valid) begin
                check("bp nibble", 16'(o.nib), 16'(nibs1234[4*beat +: 4]));
                check("bp index", 16'(o.idx), 16'(beat));
                beat++;
                if (o.out_last) last_cyc = cyc;
            end
        end
        check("bp load to last cycles", 16'(last_cyc), 16'd7);
        check("bp beats", 16'(beat), 16'd4);

        // Back-to-back: 0x00FF then 0xF00D with in_valid held high.
        @(negedge clk);
        drive(0, 1'b1, 16'h00FF, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(0, (i < 4) ? 1'b1 : 1'b0, 16'hF00D, 1'b1);
            #1 get_obs(0, o);
            check("b2b valid", 16'(o.out_valid), 16'd1);
            check("b2b nibble", 16'(o.nib), 16'(exp4[i]));
            check("b2b index", 16'(o.idx), 16'(i % 4));
            check("b2b in_ready", 16'(o.in_ready), 16'(i == 3 || i == 7));
        end
        @(negedge clk);
        drive(0, 1'b0, 16'h0, 1'b1);
        #1 get_obs(0, o);
        check("b2b idle after", 16'(o.out_valid), 16'd0);

        // Randomized traffic against the reference model, one DUT at a time.
        for (int d = 0; d < 2; d++) begin
            model_q.delete();
            for (int c = 0; c < 606; c++) begin
                logic        v;
                logic        r;
                logic [15:0] data;
                logic        exp_rdy;
                logic        exp_vld;
                bit          drain;
                drain = (c >= 600);
                v     = drain ? 1'b0 : 1'($urandom_range(0, 1));
                r     = drain ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                data  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
                @(negedge clk);
                drive(d, v, data, r);
                #1 get_obs(d, o);
                exp_vld = (model_q.size() != 0);
                exp_rdy = (model_q.size() == 0) || (model_q.size() == 1 && r);
                check("rand out_valid", 16'(o.out_valid), 16'(exp_vld));
                check("rand busy", 16'(o.busy), 16'(exp_vld));
                check("rand in_ready", 16'(o.in_ready), 16'(exp_rdy));
                if (exp_vld) begin
                    check("rand nibble", 16'(o.nib), 16'(model_q[0].nib));
                    check("rand index", 16'(o.idx), 16'(model_q[0].idx));
                    check("rand last", 16'(o.out_last), 16'(model_q[0].last));
                    if (r) void'(model_q.pop_front());
                end
                if (v && exp_rdy) push_word(data, d == 1);
            end
            check("rand drained", 16'(model_q.size()), 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
